// File: rtl/class_score_topk_ranker_pkg.sv
// rank_pkg: shared types and constants for the class-score top-K ranker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state enum, default-width score/slot types, disease class indices.
package rank_pkg;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_NUM_CLASSES = 15;
  localparam int DEF_IDX_W       = $clog2(DEF_NUM_CLASSES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic signed [DEF_DATA_WIDTH-1:0] score_t;

  // One ranked slot at the default configuration; SW decoders use this layout.
  typedef struct packed {
    logic                 valid;
    logic [DEF_IDX_W-1:0] idx;
    score_t               score;
  } slot_t;

  // Class index of each finding in the classifier output vector.
  localparam int unsigned CLS_NO_FINDING         = 0;
  localparam int unsigned CLS_ATELECTASIS        = 1;
  localparam int unsigned CLS_CARDIOMEGALY       = 2;
  localparam int unsigned CLS_EFFUSION           = 3;
  localparam int unsigned CLS_INFILTRATION       = 4;
  localparam int unsigned CLS_MASS               = 5;
  localparam int unsigned CLS_NODULE             = 6;
  localparam int unsigned CLS_PNEUMONIA          = 7;
  localparam int unsigned CLS_PNEUMOTHORAX       = 8;
  localparam int unsigned CLS_CONSOLIDATION      = 9;
  localparam int unsigned CLS_EDEMA              = 10;
  localparam int unsigned CLS_EMPHYSEMA          = 11;
  localparam int unsigned CLS_FIBROSIS           = 12;
  localparam int unsigned CLS_PLEURAL_THICKENING = 13;
  localparam int unsigned CLS_HERNIA             = 14;

endpackage

// File: rtl/class_score_topk_ranker_if.sv
// Handshake bundle between score producer / result consumer and the ranker.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the score side, out_valid/out_ready on the result side.
// master = producer+consumer side, slave = ranker side.
interface class_score_topk_ranker_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_CLASSES = 15,
  parameter int TOP_K       = 3,
  parameter int IDX_W       = $clog2(NUM_CLASSES),
  parameter int CNT_W       = $clog2(NUM_CLASSES + 1)
);
  logic                            in_valid;
  logic                            in_ready;
  logic [NUM_CLASSES*DATA_WIDTH-1:0] class_scores;
  logic [DATA_WIDTH-1:0]           threshold;
  logic                            out_valid;
  logic                            out_ready;
  logic [TOP_K*IDX_W-1:0]          topk_idx;
  logic [TOP_K*DATA_WIDTH-1:0]     topk_score;
  logic [TOP_K-1:0]                topk_above;
  logic [CNT_W-1:0]                num_above;

  modport master (
    output in_valid, class_scores, threshold, out_ready,
    input  in_ready, out_valid, topk_idx, topk_score, topk_above, num_above
  );

  modport slave (
    input  in_valid, class_scores, threshold, out_ready,
    output in_ready, out_valid, topk_idx, topk_score, topk_above, num_above
  );
endinterface

// File: rtl/class_score_topk_ranker_insert.sv
// topk_insert_unit: inserts one candidate into a descending sorted slot list.
// Latency: combinational.
// Backpressure: none.
// Ports: slot_*_i current slots (rank 0 = best), cand_*_i candidate, slot_*_o next slots.
module topk_insert_unit
  import rank_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_W      = 4,
  parameter int TOP_K      = 3
) (
  input  logic [TOP_K-1:0]            slot_vld_i,
  input  logic [TOP_K*IDX_W-1:0]      slot_idx_i,
  input  logic [TOP_K*DATA_WIDTH-1:0] slot_score_i,
  input  logic [DATA_WIDTH-1:0]       cand_score_i,
  input  logic [IDX_W-1:0]            cand_idx_i,
  output logic [TOP_K-1:0]            slot_vld_o,
  output logic [TOP_K*IDX_W-1:0]      slot_idx_o,
  output logic [TOP_K*DATA_WIDTH-1:0] slot_score_o
);

  // Slot list moved one rank down; rank 0 of these is a don't-care zero.
  logic [TOP_K-1:0]            vld_sh;
  logic [TOP_K*IDX_W-1:0]      idx_sh;
  logic [TOP_K*DATA_WIDTH-1:0] score_sh;

  assign vld_sh   = slot_vld_i << 1;
  assign idx_sh   = slot_idx_i << IDX_W;
  assign score_sh = slot_score_i << DATA_WIDTH;

  always_comb begin
    logic seen;
    logic take;
    seen         = 1'b0;
    take         = 1'b0;
    slot_vld_o   = slot_vld_i;
    slot_idx_o   = slot_idx_i;
    slot_score_o = slot_score_i;
    for (int r = 0; r < TOP_K; r++) begin
      // Strict '>' keeps an equal, earlier class ahead of the candidate.
      take = !slot_vld_i[r] ||
             ($signed(cand_score_i) > $signed(slot_score_i[r*DATA_WIDTH +: DATA_WIDTH]));
      if (seen) begin
        slot_vld_o[r]                              = vld_sh[r];
        slot_idx_o[r*IDX_W +: IDX_W]               = idx_sh[r*IDX_W +: IDX_W];
        slot_score_o[r*DATA_WIDTH +: DATA_WIDTH]   = score_sh[r*DATA_WIDTH +: DATA_WIDTH];
      end else if (take) begin
        slot_vld_o[r]                              = 1'b1;
        slot_idx_o[r*IDX_W +: IDX_W]               = cand_idx_i;
        slot_score_o[r*DATA_WIDTH +: DATA_WIDTH]   = cand_score_i;
      end
      seen = seen | take;
    end
  end

endmodule

// File: rtl/class_score_topk_ranker.sv
// class_score_topk_ranker: sequential top-K ranking of a classifier score vector.
// Latency: out_valid rises NUM_CLASSES edges after accept; one vector per NUM_CLASSES+2 cycles.
// Backpressure: in_ready only in IDLE; results held stable while out_valid && !out_ready.
// Ports: clk, rst (async, active-high), bus (slave modport: score input, ranked result output).
module class_score_topk_ranker
  import rank_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC        = 8,
  parameter int NUM_CLASSES = 15,
  parameter int TOP_K       = 3,
  parameter int IDX_W       = $clog2(NUM_CLASSES),
  parameter int CNT_W       = $clog2(NUM_CLASSES + 1)
) (
  input logic clk,
  input logic rst,
  class_score_topk_ranker_if.slave bus
);

  // FRAC only documents the score format; reject configurations that cannot hold it.
  if (FRAC > DATA_WIDTH) begin : g_bad_frac
    $error("FRAC exceeds DATA_WIDTH");
  end
  if (NUM_CLASSES < 2 || TOP_K < 1 || TOP_K > NUM_CLASSES) begin : g_bad_cfg
    $error("illegal NUM_CLASSES / TOP_K combination");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t state_q, state_d;

  logic [IDX_W-1:0]                  cnt_q, cnt_d;
  logic [NUM_CLASSES*DATA_WIDTH-1:0] scores_q, scores_d;
  logic [DATA_WIDTH-1:0]             thr_q, thr_d;
  logic [TOP_K-1:0]                  slot_vld_q, slot_vld_d;
  logic [TOP_K*IDX_W-1:0]            slot_idx_q, slot_idx_d;
  logic [TOP_K*DATA_WIDTH-1:0]       slot_score_q, slot_score_d;
  logic [CNT_W-1:0]                  num_above_q, num_above_d;

  logic [TOP_K-1:0]                  ins_vld;
  logic [TOP_K*IDX_W-1:0]            ins_idx;
  logic [TOP_K*DATA_WIDTH-1:0]       ins_score;
  logic [DATA_WIDTH-1:0]             cand_score;
  logic                              accept;

  assign accept     = (state_q == IDLE) && bus.in_valid;
  assign cand_score = scores_q[cnt_q*DATA_WIDTH +: DATA_WIDTH];

  topk_insert_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W),
    .TOP_K      (TOP_K)
  ) u_insert (
    .slot_vld_i   (slot_vld_q),
    .slot_idx_i   (slot_idx_q),
    .slot_score_i (slot_score_q),
    .cand_score_i (cand_score),
    .cand_idx_i   (cnt_q),
    .slot_vld_o   (ins_vld),
    .slot_idx_o   (ins_idx),
    .slot_score_o (ins_score)
  );

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = SCAN;
      SCAN:    if (cnt_q == LAST_IDX) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
  end

  // Datapath next state: capture on accept, one insertion per SCAN edge, hold otherwise.
  always_comb begin
    cnt_d        = cnt_q;
    scores_d     = scores_q;
    thr_d        = thr_q;
    slot_vld_d   = slot_vld_q;
    slot_idx_d   = slot_idx_q;
    slot_score_d = slot_score_q;
    num_above_d  = num_above_q;
    if (accept) begin
      scores_d     = bus.class_scores;
      thr_d        = bus.threshold;
      slot_vld_d   = '0;
      slot_idx_d   = '0;
      slot_score_d = '0;
      num_above_d  = '0;
      cnt_d        = '0;
    end else if (state_q == SCAN) begin
      slot_vld_d   = ins_vld;
      slot_idx_d   = ins_idx;
      slot_score_d = ins_score;
      if ($signed(cand_score) >= $signed(thr_q)) num_above_d = num_above_q + CNT_W'(1);
      if (cnt_q != LAST_IDX) cnt_d = cnt_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      scores_q     <= '0;
      thr_q        <= '0;
      slot_vld_q   <= '0;
      slot_idx_q   <= '0;
      slot_score_q <= '0;
      num_above_q  <= '0;
    end else begin
      cnt_q        <= cnt_d;
      scores_q     <= scores_d;
      thr_q        <= thr_d;
      slot_vld_q   <= slot_vld_d;
      slot_idx_q   <= slot_idx_d;
      slot_score_q <= slot_score_d;
      num_above_q  <= num_above_d;
    end
  end

  assign bus.topk_idx   = slot_idx_q;
  assign bus.topk_score = slot_score_q;
  assign bus.num_above  = num_above_q;

  // Gated by slot valid so cleared slots never report as above threshold.
  always_comb begin
    bus.topk_above = '0;
    for (int r = 0; r < TOP_K; r++) begin
      bus.topk_above[r] = slot_vld_q[r] &&
        ($signed(slot_score_q[r*DATA_WIDTH +: DATA_WIDTH]) >= $signed(thr_q));
    end
  end

endmodule

// File: tb/tb_class_score_topk_ranker.sv
// Bench for class_score_topk_ranker: default config plus an N=4, K=1, 8-bit instance.
// Expected results come from a selection-sort reference model (or hand constants) and are
// queued at drive time, then popped when the DUT completes an output handshake.
module tb_class_score_topk_ranker;
  import rank_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   acc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  class_score_topk_ranker_if #(.DATA_WIDTH(16), .NUM_CLASSES(15), .TOP_K(3)) m_if();
  class_score_topk_ranker_if #(.DATA_WIDTH(8),  .NUM_CLASSES(4),  .TOP_K(1)) s_if();

  class_score_topk_ranker #(.DATA_WIDTH(16), .FRAC(8), .NUM_CLASSES(15), .TOP_K(3))
    u_dut (.clk(clk), .rst(rst), .bus(m_if));
  class_score_topk_ranker #(.DATA_WIDTH(8), .FRAC(4), .NUM_CLASSES(4), .TOP_K(1))
    u_small (.clk(clk), .rst(rst), .bus(s_if));

  typedef struct packed {
    logic [11:0] idx;
    logic [47:0] score;
    logic [2:0]  above;
    logic [3:0]  num;
  } exp_m_t;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] score;
    logic       above;
    logic [2:0] num;
  } exp_s_t;

  exp_m_t q_m[$];
  exp_s_t q_s[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: pick the highest remaining score K times, lowest index wins ties.
  function automatic exp_m_t model_m(input logic [239:0] sc, input logic [15:0] thr);
    exp_m_t e;
    bit used[15];
    int best;
    logic signed [15:0] v, b;
    e = '0;
    for (int i = 0; i < 15; i++) used[i] = 1'b0;
    for (int r = 0; r < 3; r++) begin
      best = -1;
      for (int i = 0; i < 15; i++) begin
        if (!used[i]) begin
          v = sc[i*16 +: 16];
          if (best < 0) best = i;
          else begin
            b = sc[best*16 +: 16];
            if (v > b) best = i;
          end
        end
      end
      used[best] = 1'b1;
      b = sc[best*16 +: 16];
      e.idx[r*4 +: 4]    = 4'(best);
      e.score[r*16 +: 16] = b;
      e.above[r]          = (b >= $signed(thr));
    end
    for (int i = 0; i < 15; i++) begin
      v = sc[i*16 +: 16];
      if (v >= $signed(thr)) e.num = e.num + 4'd1;
    end
    return e;
  endfunction

  // Result monitor: a result is consumed on the edge after a negedge with valid && ready.
  always @(negedge clk) begin
    exp_m_t em;
    exp_s_t es;
    if (!rst && m_if.out_valid && m_if.out_ready) begin
      if (q_m.size() == 0) chk("m_unexpected_result", 64'd1, 64'd0);
      else begin
        em = q_m.pop_front();
        chk("m_idx",   64'(m_if.topk_idx),   64'(em.idx));
        chk("m_score", 64'(m_if.topk_score), 64'(em.score));
        chk("m_above", 64'(m_if.topk_above), 64'(em.above));
        chk("m_num",   64'(m_if.num_above),  64'(em.num));
      end
    end
    if (!rst && s_if.out_valid && s_if.out_ready) begin
      if (q_s.size() == 0) chk("s_unexpected_result", 64'd1, 64'd0);
      else begin
        es = q_s.pop_front();
        chk("s_idx",   64'(s_if.topk_idx),   64'(es.idx));
        chk("s_score", 64'(s_if.topk_score), 64'(es.score));
        chk("s_above", 64'(s_if.topk_above), 64'(es.above));
        chk("s_num",   64'(s_if.num_above),  64'(es.num));
      end
    end
  end

  // Called and returns at posedge+1. Accept edge is recorded in acc_cyc.
  task automatic send_m(input logic [239:0] sc, input logic [15:0] thr, input bit wait_out);
    int n;
    q_m.push_back(model_m(sc, thr));
    m_if.class_scores = sc;
    m_if.threshold    = thr;
    m_if.in_valid     = 1'b1;
    n = 0;
    while (!m_if.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!m_if.in_ready) chk("m_accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    m_if.in_valid = 1'b0;
    if (wait_out) begin
      n = 0;
      while (!m_if.out_valid && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      chk("m_latency", 64'(n), 64'd15);
    end
  endtask

  task automatic send_s(input logic [31:0] sc, input logic [7:0] thr, input exp_s_t e);
    int n;
    q_s.push_back(e);
    s_if.class_scores = sc;
    s_if.threshold    = thr;
    s_if.in_valid     = 1'b1;
    n = 0;
    while (!s_if.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!s_if.in_ready) chk("s_accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    s_if.in_valid = 1'b0;
    n = 0;
    while (!s_if.out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("s_latency", 64'(n), 64'd4);
  endtask

  task automatic wait_m_out(input string tag);
    int n;
    n = 0;
    while (!m_if.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!m_if.out_valid) chk(tag, 64'd0, 64'd1);
  endtask

  logic [239:0] ramp, zeros, sgn, va, vb, vr;
  exp_m_t       ea;
  int           prev;

  initial begin
    m_if.in_valid = 1'b0; m_if.out_ready = 1'b1;
    m_if.class_scores = '0; m_if.threshold = '0;
    s_if.in_valid = 1'b0; s_if.out_ready = 1'b1;
    s_if.class_scores = '0; s_if.threshold = '0;

    for (int i = 0; i < 15; i++) begin
      ramp[i*16 +: 16] = 16'(i * 16);
      sgn[i*16 +: 16]  = 16'h8000;
    end
    zeros = '0;
    sgn[5*16 +: 16] = 16'hFFFF;
    sgn[9*16 +: 16] = 16'h0001;

    // Reset state
    #1;
    chk("rst_in_ready",  64'(m_if.in_ready),   64'd1);
    chk("rst_out_valid", 64'(m_if.out_valid),  64'd0);
    chk("rst_idx",       64'(m_if.topk_idx),   64'd0);
    chk("rst_score",     64'(m_if.topk_score), 64'd0);
    chk("rst_above",     64'(m_if.topk_above), 64'd0);
    chk("rst_num",       64'(m_if.num_above),  64'd0);
    chk("rst_s_in_ready", 64'(s_if.in_ready),  64'd1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Ramp: top three are the last three classes, 7 classes at or above 0x0080
    send_m(ramp, 16'h0080, 1'b1);
    chk("t1_idx",   64'(m_if.topk_idx),   {52'd0, 4'd12, 4'd13, 4'd14});
    chk("t1_score", 64'(m_if.topk_score), {16'd0, 16'h00C0, 16'h00D0, 16'h00E0});
    chk("t1_num",   64'(m_if.num_above),  64'd7);
    // Equal scores: index order preserved
    send_m(zeros, 16'h0000, 1'b1);
    // Signed ordering with minimum values present
    send_m(sgn, 16'h0000, 1'b1);
    chk("t3_above", 64'(m_if.topk_above), 64'b001);

    // Back-to-back random vectors with throughput check
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 15; i++) vr[i*16 +: 16] = 16'($urandom);
      prev = acc_cyc;
      send_m(vr, 16'($urandom), 1'b1);
      if (k > 0) chk("thruput", 64'(acc_cyc - prev), 64'd17);
    end
    @(posedge clk); #1;

    // Backpressure: result held, in_ready low, pending vector not taken
    for (int i = 0; i < 15; i++) begin
      va[i*16 +: 16] = 16'($urandom);
      vb[i*16 +: 16] = 16'($urandom);
    end
    m_if.out_ready = 1'b0;
    ea = model_m(va, 16'h0100);
    send_m(va, 16'h0100, 1'b1);
    q_m.push_back(model_m(vb, 16'hFF00));
    m_if.class_scores = vb;
    m_if.threshold    = 16'hFF00;
    for (int c = 0; c < 20; c++) begin
      m_if.in_valid = (c % 3 != 2);
      chk("bp_in_ready",  64'(m_if.in_ready),   64'd0);
      chk("bp_out_valid", 64'(m_if.out_valid),  64'd1);
      chk("bp_idx",       64'(m_if.topk_idx),   64'(ea.idx));
      chk("bp_score",     64'(m_if.topk_score), 64'(ea.score));
      chk("bp_above",     64'(m_if.topk_above), 64'(ea.above));
      chk("bp_num",       64'(m_if.num_above),  64'(ea.num));
      @(posedge clk); #1;
    end
    m_if.in_valid  = 1'b1;
    m_if.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", 64'(m_if.out_valid), 64'd0);
    chk("bp_release_in_ready",  64'(m_if.in_ready),  64'd1);
    @(posedge clk); #1;
    m_if.in_valid = 1'b0;
    chk("bp_pending_taken", 64'(m_if.in_ready), 64'd0);
    wait_m_out("bp_second_timeout");
    @(posedge clk); #1;

    // Reset in the middle of a scan discards it
    send_m(ramp, 16'h0080, 1'b0);
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    void'(q_m.pop_back());
    chk("mid_rst_out_valid", 64'(m_if.out_valid),  64'd0);
    chk("mid_rst_in_ready",  64'(m_if.in_ready),   64'd1);
    chk("mid_rst_idx",       64'(m_if.topk_idx),   64'd0);
    chk("mid_rst_score",     64'(m_if.topk_score), 64'd0);
    chk("mid_rst_above",     64'(m_if.topk_above), 64'd0);
    chk("mid_rst_num",       64'(m_if.num_above),  64'd0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 64'(m_if.in_ready), 64'd1);
    send_m(ramp, 16'h0080, 1'b1);
    @(posedge clk); #1;

    // Small configuration: N=4, K=1, 8-bit scores
    send_s(32'h02_09_09_05, 8'd9,   '{idx: 2'd1, score: 8'd9,   above: 1'b1, num: 3'd2});
    @(posedge clk); #1;
    send_s(32'h7F_7F_80_FD, 8'hFD,  '{idx: 2'd2, score: 8'h7F, above: 1'b1, num: 3'd3});
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;

    chk("m_queue_drained", 64'(q_m.size()), 64'd0);
    chk("s_queue_drained", 64'(q_s.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/class_score_topk_ranker.md
Name: class_score_topk_ranker

Overview:
Post-classifier result ranker that sits after full_system_top's final layer.
- Accepts one packed vector of NUM_CLASSES signed fixed-point class scores through a valid/ready handshake.
- Scans the vector sequentially, one class per cycle, and keeps a sorted top-K list of scores and class indices.
- Flags each top-K entry against a runtime threshold and counts how many classes reach that threshold.
- Generalises the single-argmax diagnosis step to K ranked findings, configurable width and class count, and threshold screening.

Parameters:
- DATA_WIDTH, 16, score width (signed, two's complement).
- FRAC, 8, fractional bits. Informational only; no arithmetic depends on it.
- NUM_CLASSES, 15, number of class scores per vector (>=2).
- TOP_K, 3, number of ranked outputs (1 <= TOP_K <= NUM_CLASSES).
- IDX_W, $clog2(NUM_CLASSES), class index width.
- CNT_W, $clog2(NUM_CLASSES+1), width of num_above.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  score vector present.
- in_ready  out  1  block can accept a vector (high only in IDLE).
- class_scores  in  NUM_CLASSES*DATA_WIDTH  class i at [i*DATA_WIDTH +: DATA_WIDTH].
- threshold  in  DATA_WIDTH  signed screening threshold, sampled at accept.
- out_valid  out  1  ranked result available.
- out_ready  in  1  consumer accepts the result.
- topk_idx  out  TOP_K*IDX_W  rank r at [r*IDX_W +: IDX_W]; rank 0 is the highest score.
- topk_score  out  TOP_K*DATA_WIDTH  scores matching topk_idx.
- topk_above  out  TOP_K  bit r = topk_score[r] >= threshold.
- num_above  out  CNT_W  count of classes with score >= threshold.

Behaviour:
- Reset: one clock (clk); rst is asynchronous, active-high. On reset:
  - state = IDLE;
  - in_ready = 1;
  - out_valid = 0;
  - topk_idx, topk_score, topk_above, num_above, internal slot-valid bits, scan counter and captured vector all = 0.
- Reset asserted mid-SCAN or mid-DONE discards the operation immediately. No partial result is ever presented.
- FSM states are IDLE, SCAN and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid at the edge: capture class_scores and threshold; clear all slots (valid = 0, score/idx = 0) and num_above; set cnt = 0; go to SCAN.
  - Outputs keep the previous result until that accept clears them.
- SCAN:
  - in_ready = 0; out_valid = 0.
  - Each edge processes class cnt, with s = score[cnt].
  - Insertion position p = the lowest rank r where slot r is invalid or s > slot_score[r] (signed, strict).
  - If such a p exists: shift slots p..TOP_K-2 down one place, write (s, cnt) into slot p, set it valid. Otherwise drop the class.
  - Ties keep the earlier (lower-index) class ahead.
  - num_above increments when s >= threshold.
  - When cnt == NUM_CLASSES-1, go to DONE; otherwise cnt++.
  - SCAN occupies exactly NUM_CLASSES edges. out_valid rises NUM_CLASSES edges after the accepting edge (15 for the defaults).
- DONE:
  - out_valid = 1; in_ready = 0.
  - All outputs are held stable while out_valid && !out_ready.
  - On out_ready: go to IDLE, out_valid = 0 next cycle, in_ready = 1 next cycle. Back-to-back throughput is one vector per NUM_CLASSES+2 cycles.
  - in_valid while not in IDLE is ignored. The producer must hold it until in_ready.
- topk_above is computed from the slot registers and the latched threshold. It is registered or combinational, but it must be valid whenever out_valid = 1.
- All TOP_K slots are always filled at DONE, because TOP_K <= NUM_CLASSES.
- Comparisons use $signed on DATA_WIDTH values. 0x8000 is the minimum value and is ranked like any other score. num_above saturates at NUM_CLASSES by construction.

Decomposition:
- Package rank_pkg holds:
  - the state enum (IDLE, SCAN, DONE);
  - the score_t typedef (signed DATA_WIDTH);
  - the slot struct {valid, idx, score};
  - the disease index constants (0 = No Finding … 14 = Hernia) for bench and SW reporting.
- One sub-module, topk_insert_unit: combinational. Inputs are the current slot array and the candidate (score, idx). Output is the next slot array. Parametrised by TOP_K.
- The top level holds the FSM, counter, capture registers and handshake.

Test Plan:
1. N=15, K=3; score[i] = i*0x0010; threshold = 0x0080; out_ready = 1 → idx {14,13,12}, scores {0x00E0,0x00D0,0x00C0}, above = 3'b111, num_above = 7, out_valid exactly 15 edges after accept.
2. All scores 0x0000, threshold 0x0000 → idx {0,1,2} (tie order), all scores 0, above = 3'b111, num_above = 15.
3. Signed: all 0x8000 except score[5] = 0xFFFF and score[9] = 0x0001; threshold 0x0000 → idx {9,5,0}, scores {0x0001,0xFFFF,0x8000}, above = 3'b001 (rank 0 only), num_above = 1.
4. Backpressure: hold out_ready = 0 for 20 cycles after out_valid, with in_valid pulsed meanwhile → outputs bit-stable, in_ready = 0, second vector not taken. Raise out_ready → in_ready = 1 next cycle and the pending vector is then accepted.
5. Assert rst at the 7th SCAN edge → out_valid = 0 and all outputs 0 asynchronously. After release, in_ready = 1; rerunning test 1 gives identical results.
6. Config N=4, K=1, DATA_WIDTH=8: scores {5,9,9,2}, threshold 9 → idx {1}, score 9, above = 1, num_above = 2, latency 4 edges.
